ifetch_queue: RTL and testbench

Parametrised instruction-fetch front end with a decoupling fetch queue, sitting between the icache and the issue/dispatch stage. Each cycle it generates the fetch PC, redirects on predicted-taken branches and JAL, and stalls behind JALR until the ALU resolves it. Fetched instructions go into a DEPTH-entry FIFO with their PC and prediction bit. Issue drains the FIFO through a valid/ready handshake, so a full ROB, RS or LSB no longer discards fetch work.

---
 rtl/ifetch_queue_pkg.sv | 28 ++
 rtl/ifetch_queue_fifo.sv | 68 ++++++
 rtl/ifetch_queue.sv | 100 ++++++++++
 tb/tb_ifetch_queue.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ifetch_queue_pkg.sv
// Shared opcode constants, queue entry type and immediate decoders for the
// instruction-fetch front end.
package ifetch_queue_pkg;

  localparam logic [6:0] BOP  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        predict;
  } fq_entry_t;

  localparam int ENTRY_W = $bits(fq_entry_t);

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/ifetch_queue_fifo.sv
// Generic DEPTH x WIDTH FIFO: synchronous write, combinational read of the head.
// Clear outranks push/pop; en low freezes all state.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (en) begin
      if (clear) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (push) tail_d = tail_q + AW'(1);
        if (pop)  head_d = head_q + AW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (en && push && !clear) begin
      mem_q[tail_q] <= wdata;
    end
  end

  assign rdata = mem_q[head_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/ifetch_queue.sv
// Fetch PC generator with branch/JAL redirect and JALR stall, feeding a
// decoupling queue that the issue stage drains via valid/ready.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        icache_enable,
  output logic [31:0] pc_to_icache,
  input  logic        icache_valid,
  input  logic [31:0] icache_inst,
  output logic [31:0] pred_pc,
  input  logic        pred_taken,
  output logic        issue_valid,
  input  logic        issue_ready,
  output logic [31:0] issue_inst,
  output logic [31:0] issue_pc,
  output logic        issue_predict,
  input  logic        jalr_valid,
  input  logic [31:0] jalr_pc,
  input  logic        rollback,
  input  logic [31:0] ROB_reset_pc
);

  logic [31:0] pc_q, pc_d;
  logic        stall_q, stall_d;
  logic        fifo_full, fifo_empty;
  logic        push, pop, clear;
  logic [6:0]  opcode;
  fq_entry_t   wr_entry, rd_entry;

  assign opcode = icache_inst[6:0];

  // Enable deliberately ignores issue_ready so no ready->request path exists.
  assign icache_enable = !stall_q && !fifo_full && !rollback && !jalr_valid;
  assign push  = icache_enable && icache_valid;
  assign pop   = issue_valid && issue_ready;
  assign clear = rollback || jalr_valid;

  assign wr_entry.inst    = icache_inst;
  assign wr_entry.pc      = pc_q;
  assign wr_entry.predict = pred_taken && (opcode == BOP);

  always_comb begin
    pc_d    = pc_q;
    stall_d = stall_q;
    if (rdy) begin
      if (rollback) begin
        pc_d    = ROB_reset_pc;
        stall_d = False;
      end else if (jalr_valid) begin
        pc_d    = jalr_pc;
        stall_d = False;
      end else if (push) begin
        if (opcode == BOP && pred_taken) pc_d = pc_q + imm_b(icache_inst);
        else if (opcode == JAL)          pc_d = pc_q + imm_j(icache_inst);
        else if (opcode == JALR)         stall_d = True;
        else                             pc_d = pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      stall_q <= False;
    end else begin
      pc_q    <= pc_d;
      stall_q <= stall_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .en    (rdy),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign pc_to_icache  = pc_q;
  assign pred_pc       = pc_q;
  assign issue_valid   = !fifo_empty;
  assign issue_inst    = rd_entry.inst;
  assign issue_pc      = rd_entry.pc;
  assign issue_predict = rd_entry.predict;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with DEPTH=4 and RESET_PC=0x100.
module tb_ifetch_queue;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] BEQ_M8 = 32'hFE00_0CE3;
  localparam logic [31:0] JAL_40 = 32'h0400_006F;
  localparam logic [31:0] JALR_I = 32'h0000_8067;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        icache_enable, icache_valid;
  logic [31:0] pc_to_icache, icache_inst, pred_pc;
  logic        pred_taken, issue_valid, issue_ready, issue_predict;
  logic [31:0] issue_inst, issue_pc;
  logic        jalr_valid, rollback;
  logic [31:0] jalr_pc, ROB_reset_pc;

  int total = 0;
  int bad   = 0;

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'h100)) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .icache_enable (icache_enable),
    .pc_to_icache  (pc_to_icache),
    .icache_valid  (icache_valid),
    .icache_inst   (icache_inst),
    .pred_pc       (pred_pc),
    .pred_taken    (pred_taken),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_inst    (issue_inst),
    .issue_pc      (issue_pc),
    .issue_predict (issue_predict),
    .jalr_valid    (jalr_valid),
    .jalr_pc       (jalr_pc),
    .rollback      (rollback),
    .ROB_reset_pc  (ROB_reset_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; icache_valid = 1'b0; icache_inst = NOP;
    pred_taken = 1'b0; issue_ready = 1'b0; jalr_valid = 1'b0; jalr_pc = '0;
    rollback = 1'b0; ROB_reset_pc = '0;
    #3;
    chk("rst_pc", pc_to_icache, 32'h100);
    chk("rst_valid", {31'b0, issue_valid}, 32'd0);
    chk("rst_en", {31'b0, icache_enable}, 32'd1);
    chk("rst_ipc", issue_pc, 32'h0);
    chk("rst_inst", issue_inst, 32'h0);
    #1 rst = 1'b0;

    // straight-line code with issue_ready high
    icache_valid = 1'b1; icache_inst = NOP; issue_ready = 1'b1;
    #0;
    chk("seq_pre_valid", {31'b0, issue_valid}, 32'd0);
    tick();
    chk("seq_valid0", {31'b0, issue_valid}, 32'd1);
    chk("seq_ipc0", issue_pc, 32'h100);
    chk("seq_pc0", pc_to_icache, 32'h104);
    tick();
    chk("seq_ipc1", issue_pc, 32'h104);
    tick();
    chk("seq_ipc2", issue_pc, 32'h108);
    chk("seq_pc2", pc_to_icache, 32'h10C);
    icache_valid = 1'b0;
    tick();
    chk("seq_drained", {31'b0, issue_valid}, 32'd0);

    // back-pressure: fill to DEPTH, enable must drop
    issue_ready = 1'b0; icache_valid = 1'b1;
    repeat (4) tick();
    chk("bp_en_full", {31'b0, icache_enable}, 32'd0);
    chk("bp_pc", pc_to_icache, 32'h11C);
    tick();
    chk("bp_pc_hold", pc_to_icache, 32'h11C);
    issue_ready = 1'b1;
    #1;
    chk("bp_en_no_ready_path", {31'b0, icache_enable}, 32'd0);
    chk("bp_head0", issue_pc, 32'h10C);
    tick();
    issue_ready = 1'b0; icache_valid = 1'b0;
    #1;
    chk("bp_head1", issue_pc, 32'h110);
    chk("bp_en_after_pop", {31'b0, icache_enable}, 32'd1);

    // rollback and jalr_valid together with 3 entries queued
    rollback = 1'b1; jalr_valid = 1'b1; ROB_reset_pc = 32'h400; jalr_pc = 32'h200;
    #1;
    chk("rb_en_low", {31'b0, icache_enable}, 32'd0);
    tick();
    rollback = 1'b0; jalr_valid = 1'b0;
    #1;
    chk("rb_pc", pc_to_icache, 32'h400);
    chk("rb_valid", {31'b0, issue_valid}, 32'd0);
    chk("rb_stall_clear", {31'b0, icache_enable}, 32'd1);

    // rdy low freezes state
    rollback = 1'b1; ROB_reset_pc = 32'h10; rdy = 1'b0;
    tick();
    chk("rdy_hold", pc_to_icache, 32'h400);
    rdy = 1'b1;
    tick();
    rollback = 1'b0;
    chk("rdy_resume", pc_to_icache, 32'h10);

    // BEQ at 0x10, predicted taken
    icache_valid = 1'b1; icache_inst = BEQ_M8; pred_taken = 1'b1;
    #1;
    chk("pred_pc", pred_pc, 32'h10);
    tick();
    icache_valid = 1'b0;
    chk("beq_t_pc", pc_to_icache, 32'h08);
    chk("beq_t_pred", {31'b0, issue_predict}, 32'd1);
    chk("beq_t_ipc", issue_pc, 32'h10);

    // BEQ at 0x10, predicted not taken
    rollback = 1'b1; ROB_reset_pc = 32'h10;
    tick();
    rollback = 1'b0;
    chk("beq_flush", {31'b0, issue_valid}, 32'd0);
    icache_valid = 1'b1; pred_taken = 1'b0;
    tick();
    icache_valid = 1'b0;
    chk("beq_nt_pc", pc_to_icache, 32'h14);
    chk("beq_nt_pred", {31'b0, issue_predict}, 32'd0);

    // JAL at 0x20; prediction bit must not be set for non-branches
    rollback = 1'b1; ROB_reset_pc = 32'h20;
    tick();
    rollback = 1'b0;
    icache_valid = 1'b1; icache_inst = JAL_40; pred_taken = 1'b1;
    tick();
    icache_valid = 1'b0; pred_taken = 1'b0;
    chk("jal_pc", pc_to_icache, 32'h60);
    chk("jal_pred", {31'b0, issue_predict}, 32'd0);
    chk("jal_inst", issue_inst, JAL_40);

    // JALR at 0x60 stalls until resolved
    icache_valid = 1'b1; icache_inst = JALR_I; issue_ready = 1'b1;
    tick();
    icache_inst = NOP;
    #1;
    chk("jalr_en", {31'b0, icache_enable}, 32'd0);
    chk("jalr_pc_hold", pc_to_icache, 32'h60);
    chk("jalr_ipc", issue_pc, 32'h60);
    tick();
    chk("jalr_stall_empty", {31'b0, issue_valid}, 32'd0);
    chk("jalr_stall_en", {31'b0, icache_enable}, 32'd0);
    jalr_valid = 1'b1; jalr_pc = 32'h200;
    tick();
    jalr_valid = 1'b0;
    #1;
    chk("jalr_target", pc_to_icache, 32'h200);
    chk("jalr_q_empty", {31'b0, issue_valid}, 32'd0);
    chk("jalr_en_back", {31'b0, icache_enable}, 32'd1);

    // asynchronous reset mid-stream
    issue_ready = 1'b0;
    tick();
    tick();
    chk("pre_arst_pc", pc_to_icache, 32'h208);
    chk("pre_arst_valid", {31'b0, issue_valid}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_pc", pc_to_icache, 32'h100);
    chk("arst_valid", {31'b0, issue_valid}, 32'd0);
    rst = 1'b0; icache_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
